// File: rtl/lea_block_loader.sv
// Purpose: assembles DEPTH beats of WIDTH bits into one parallel LEA block (plaintext or key); optional macro LEA_LOADER_ZERO_BUBBLE_EN.
// Latency: out_valid rises one cycle after the DEPTH-th beat is accepted; unload clears the block on the out_ready edge.
// Backpressure: in_ready is low while a block is held, so the source holds its beat; with the macro, unload and next accept share one edge.
module lea_block_loader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CLR,
  input  logic                   DIR,
  input  logic [WIDTH-1:0]       Din,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DEPTH*WIDTH-1:0] Dout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t                 state_q, state_d;
  logic [DEPTH*WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dir_q, dir_d;
  logic                   accept;
  logic                   wr_en;
  logic [CNT_W-1:0]       wr_idx;

  // Ready comes from the registered state only; the zero-bubble build also lets an unload free the slot.
  always_comb begin
`ifdef LEA_LOADER_ZERO_BUBBLE_EN
    in_ready = (state_q != FULL) || out_ready;
`else
    in_ready = (state_q != FULL);
`endif
  end

  assign accept = in_valid && in_ready;

  // Next-state and slot-write decode; CLR overrides everything, including a beat offered this cycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    if (CLR) begin
      state_d = IDLE;
      data_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            // First beat fixes the fill order for the whole block.
            dir_d   = DIR;
            wr_en   = 1'b1;
            wr_idx  = DIR ? LAST : '0;
            cnt_d   = ONE;
            state_d = FILL;
          end
        end
        FILL: begin
          if (accept) begin
            wr_en   = 1'b1;
            wr_idx  = dir_q ? (LAST - cnt_q) : cnt_q;
            cnt_d   = cnt_q + ONE;
            state_d = (cnt_q == LAST) ? FULL : FILL;
          end
        end
        FULL: begin
          if (out_ready) begin
            data_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
`ifdef LEA_LOADER_ZERO_BUBBLE_EN
            // Unload and start the next block on the same edge.
            if (accept) begin
              dir_d   = DIR;
              wr_en   = 1'b1;
              wr_idx  = DIR ? LAST : '0;
              cnt_d   = ONE;
              state_d = FILL;
            end
`endif
          end
        end
        default: begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
        end
      endcase
      if (wr_en) begin
        data_d[int'(wr_idx)*WIDTH +: WIDTH] = Din;
      end
    end
  end

  // State, block storage, beat count and latched direction.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign Dout      = data_q;
  assign count     = cnt_q;
  assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_lea_block_loader.sv
// Bench for lea_block_loader: four parameter sets driven together, a beat-list model per instance,
// a per-cycle compare of every output, directed cases on the 8x16 instance, then random traffic.
module tb_lea_block_loader;

  localparam int NI = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr  [NI];
  logic         dir  [NI];
  logic         iv   [NI];
  logic         ordy [NI];
  logic [31:0]  din  [NI];
  logic         irdy [NI];
  logic         ov   [NI];
  logic [255:0] dout [NI];
  logic [5:0]   cnt  [NI];

  int checks = 0;
  int errors = 0;
  int blk_seen [NI] = '{default: 0};

  // Reference model: beats in arrival order, fill direction of the current block, completed unloads.
  int          m_n    [NI] = '{default: 0};
  logic        m_dir  [NI];
  logic [31:0] m_beat [NI][32];
  int          m_unl  [NI] = '{default: 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int W  = (g == 3) ? 32 : 8;
    localparam int D  = (g == 0) ? 16 : (g == 1) ? 24 : (g == 2) ? 32 : 4;
    localparam int CW = $clog2(D + 1);
    logic [D*W-1:0] blk;
    logic [CW-1:0]  c;
    lea_block_loader #(.WIDTH(W), .DEPTH(D)) u_dut (
      .CLK       (clk),
      .RST       (rst),
      .CLR       (clr[g]),
      .DIR       (dir[g]),
      .Din       (din[g][W-1:0]),
      .in_valid  (iv[g]),
      .in_ready  (irdy[g]),
      .Dout      (blk),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .count     (c)
    );
    assign dout[g] = 256'(blk);
    assign cnt[g]  = 6'(c);
  end

  function automatic int cfg_w(int g);
    return (g == 3) ? 32 : 8;
  endfunction

  function automatic int cfg_d(int g);
    case (g)
      0:       return 16;
      1:       return 24;
      2:       return 32;
      default: return 4;
    endcase
  endfunction

  function automatic bit m_rdy(int g);
`ifdef LEA_LOADER_ZERO_BUBBLE_EN
    return (m_n[g] != cfg_d(g)) || ordy[g];
`else
    return m_n[g] != cfg_d(g);
`endif
  endfunction

  // Expected block: beat k lands in slot k, or slot DEPTH-1-k for reverse order; unwritten slots are zero.
  function automatic logic [255:0] exp_dout(int g);
    logic [255:0] r;
    int w;
    int d;
    int s;
    r = '0;
    w = cfg_w(g);
    d = cfg_d(g);
    for (int k = 0; k < m_n[g]; k++) begin
      s = m_dir[g] ? (d - 1 - k) : k;
      for (int b = 0; b < w; b++) r[s*w + b] = m_beat[g][k][b];
    end
    return r;
  endfunction

  // Model update at each edge from the inputs the DUT sees; async reset empties it.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < NI; g++) begin
        m_n[g]   <= 0;
        m_dir[g] <= 1'b0;
      end
    end else begin
      for (int g = 0; g < NI; g++) begin
        if (clr[g]) begin
          m_n[g] <= 0;
        end else if (m_n[g] == cfg_d(g) && ordy[g]) begin
          m_unl[g] <= m_unl[g] + 1;
`ifdef LEA_LOADER_ZERO_BUBBLE_EN
          if (iv[g]) begin
            m_beat[g][0] <= din[g];
            m_dir[g]     <= dir[g];
            m_n[g]       <= 1;
          end else begin
            m_n[g] <= 0;
          end
`else
          m_n[g] <= 0;
`endif
        end else if (iv[g] && m_n[g] != cfg_d(g)) begin
          if (m_n[g] == 0) m_dir[g] <= dir[g];
          m_beat[g][m_n[g]] <= din[g];
          m_n[g]            <= m_n[g] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  task automatic compare_all();
    if (rst === 1'b1) begin
      for (int g = 0; g < NI; g++) begin
        check($sformatf("count[%0d]", g), 256'(cnt[g]), 256'(m_n[g]));
        check($sformatf("out_valid[%0d]", g), 256'(ov[g]), 256'(m_n[g] == cfg_d(g)));
        check($sformatf("in_ready[%0d]", g), 256'(irdy[g]), 256'(m_rdy(g)));
        check($sformatf("Dout[%0d]", g), dout[g], exp_dout(g));
        if (ov[g] && ordy[g] && !clr[g]) blk_seen[g]++;
      end
    end
  endtask

  // Compare on the falling edge, then return 2 ns after the rising edge for the next drive.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int ovc;
    rst = 1'b0;
    for (int g = 0; g < NI; g++) begin
      clr[g] = 1'b0; dir[g] = 1'b0; iv[g] = 1'b0; ordy[g] = 1'b0; din[g] = '0;
    end
    #1;
    check("reset count", 256'(cnt[0]), 256'(0));
    check("reset out_valid", 256'(ov[0]), 256'(0));
    check("reset Dout", dout[0], 256'(0));
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("ready after reset", 256'(irdy[0]), 256'(1));

    // Partial stream, then asynchronous reset mid-stream.
    iv[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[0] = 32'(8'hE0 + k);
      tick();
    end
    check("partial count", 256'(cnt[0]), 256'(3));
    rst = 1'b0;
    #1;
    check("async reset count", 256'(cnt[0]), 256'(0));
    tick();
    rst = 1'b1;

    // Forward fill 0x00..0x0F with in_valid held.
    for (int k = 0; k < 16; k++) begin
      din[0] = 32'(k);
      tick();
      check($sformatf("fill count beat %0d", k), 256'(cnt[0]), 256'(k + 1));
      if (k == 14) check("ready before last", 256'(irdy[0]), 256'(1));
    end
    iv[0] = 1'b0;
    check("ready after last", 256'(irdy[0]), 256'(0));
    check("valid after last", 256'(ov[0]), 256'(1));
    check("slot0 fwd", 256'(dout[0][7:0]), 256'(8'h00));
    check("slot15 fwd", 256'(dout[0][127:120]), 256'(8'h0F));
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    check("unload count", 256'(cnt[0]), 256'(0));

    // Reverse fill; DIR toggles mid-block and must be ignored.
    iv[0] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      dir[0] = (k < 8);
      din[0] = 32'(8'hA0 + k);
      tick();
    end
    check("slot15 rev", 256'(dout[0][127:120]), 256'(8'hA0));
    check("slot0 rev", 256'(dout[0][7:0]), 256'(8'hAF));
    check("slot8 rev", 256'(dout[0][71:64]), 256'(8'hA7));

    // Backpressure: held block stays put while a beat waits.
    dir[0] = 1'b0;
    din[0] = 32'h55;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold count", 256'(cnt[0]), 256'(16));
      check("hold ready", 256'(irdy[0]), 256'(0));
      check("hold slot0", 256'(dout[0][7:0]), 256'(8'hAF));
      check("hold slot15", 256'(dout[0][127:120]), 256'(8'hA0));
    end
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
`ifdef LEA_LOADER_ZERO_BUBBLE_EN
    check("zb unload count", 256'(cnt[0]), 256'(1));
    check("zb unload valid", 256'(ov[0]), 256'(0));
    check("zb 0x55 slot0", 256'(dout[0][7:0]), 256'(8'h55));
`else
    check("unload count 0", 256'(cnt[0]), 256'(0));
    check("unload valid", 256'(ov[0]), 256'(0));
    check("unload Dout", dout[0], 256'(0));
    check("bubble ready", 256'(irdy[0]), 256'(1));
    tick();
    check("0x55 count", 256'(cnt[0]), 256'(1));
    check("0x55 block", dout[0], 256'(8'h55));
`endif
    iv[0] = 1'b0;

    // Synchronous clear drops the beat offered alongside it.
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    iv[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      din[0] = 32'(k);
      tick();
    end
    check("pre-clear count", 256'(cnt[0]), 256'(7));
    clr[0] = 1'b1;
    din[0] = 32'h99;
    tick();
    clr[0] = 1'b0;
    iv[0]  = 1'b0;
    check("clear count", 256'(cnt[0]), 256'(0));
    check("clear Dout", dout[0], 256'(0));
    tick();
    check("clear dropped beat", 256'(cnt[0]), 256'(0));

    // Asynchronous reset between edges with a partial block.
    iv[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      din[0] = 32'(8'h30 + k);
      tick();
    end
    iv[0] = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("async count", 256'(cnt[0]), 256'(0));
    check("async Dout", dout[0], 256'(0));
    check("async valid", 256'(ov[0]), 256'(0));
    tick();
    rst = 1'b1;

`ifdef LEA_LOADER_ZERO_BUBBLE_EN
    // Continuous stream across block boundaries.
    ovc = 0;
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      din[0] = 32'(k & 8'hFF);
      tick();
      check("zb ready", 256'(irdy[0]), 256'(1));
      if (ov[0]) ovc++;
      if (k == 16) begin
        check("zb beat17 count", 256'(cnt[0]), 256'(1));
        check("zb beat17 slot0", 256'(dout[0][7:0]), 256'(8'h10));
      end
    end
    check("zb valid cycles", 256'(ovc), 256'(2));
    iv[0] = 1'b0;
    ordy[0] = 1'b0;
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
`else
    ovc = 0;
`endif

    // Random traffic on all instances.
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < NI; g++) begin
        iv[g]   = ($urandom_range(3) != 0);
        din[g]  = $urandom;
        dir[g]  = 1'($urandom_range(1));
        ordy[g] = 1'($urandom_range(1));
        clr[g]  = ($urandom_range(149) == 0);
      end
      tick();
    end
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0; ordy[g] = 1'b0; clr[g] = 1'b0;
    end
    tick();
    tick();
    for (int g = 0; g < NI; g++) begin
      check($sformatf("blocks unloaded[%0d]", g), 256'(blk_seen[g]), 256'(m_unl[g]));
      check($sformatf("some blocks[%0d]", g), 256'(blk_seen[g] > 0), 256'(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lea_block_loader.md
Name: lea_block_loader

Overview:
- Parametrised byte-serial to parallel loader for the LEA datapath. It replaces the fixed 16-stage 8-bit shift chain.
- Accepts WIDTH-bit beats over a valid/ready handshake and assembles DEPTH beats into one parallel block: 16 bytes for plaintext or a 128-bit key, 24/32 bytes for 192/256-bit keys.
- Presents the block with out_valid, holds it until the consumer acknowledges, then clears it.
- Sits between the host byte interface and the round-key or encryption core.

Parameters:
- WIDTH, 8, beat width in bits (>=1).
- DEPTH, 16, beats per block (>=2).
- CNT_W, $clog2(DEPTH+1), width of the count output (derived; do not override).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- CLR  in  1  synchronous clear; discards the partial or held block.
- DIR  in  1  fill order: 0 = first beat to slot 0; 1 = first beat to slot DEPTH-1.
- Din  in  WIDTH  input beat.
- in_valid  in  1  Din is valid.
- in_ready  out  1  loader can accept a beat.
- Dout  out  DEPTH*WIDTH  assembled block; slot i at [i*WIDTH +: WIDTH].
- out_valid  out  1  Dout holds a complete block.
- out_ready  in  1  consumer takes the block.
- count  out  CNT_W  beats currently stored (0..DEPTH).

Behaviour:
- Reset (RST low, asynchronous): all slots 0, count 0, out_valid 0, latched direction 0. in_ready is 1 once RST is high.
- The state machine has three states: IDLE (count=0), FILL (0<count<DEPTH), FULL (count=DEPTH).
- A beat is accepted when in_valid && in_ready at a rising CLK edge.
- in_ready = (state != FULL), combinational from state only. It has no combinational path from in_valid.
- Accepting in IDLE:
  - Latches DIR as dir_q; DIR is ignored for the rest of the block.
  - Writes Din to slot 0 if DIR=0, or slot DEPTH-1 if DIR=1.
  - count becomes 1.
- Accepting in FILL: writes slot count (dir_q=0) or slot DEPTH-1-count (dir_q=1), then count+1.
  - Slots not yet written this block read 0.
- When the DEPTH-th beat is accepted, the next state is FULL and out_valid=1 in the cycle after that edge (one cycle latency).
- In FULL, Dout and count (=DEPTH) stay stable regardless of Din, in_valid or DIR.
- In FULL with out_ready=1 at an edge:
  - All slots clear to 0, count becomes 0, out_valid becomes 0, next state IDLE.
  - in_ready rises the following cycle, so there is one bubble (unless the optional feature is enabled).
- out_ready is ignored when out_valid=0.
- CLR=1 at an edge:
  - Takes priority over everything: slots cleared, count 0, out_valid 0, IDLE.
  - A beat offered in the same cycle is dropped, even though in_ready was 1.
- in_valid while in FULL is not accepted. The source must hold it, and no data is lost.
- RST asserted mid-block aborts immediately to the reset state. A partial block is never presented.
- count never exceeds DEPTH and never wraps.

Optional Feature:
- Macro: LEA_LOADER_ZERO_BUBBLE_EN.
- Defined:
  - in_ready = (state != FULL) || out_ready.
  - In FULL, an edge with out_ready && in_valid unloads the block and accepts Din as beat 0 of the next block in the same edge, latching DIR at that edge. Result: count=1, state FILL, out_valid=0.
  - CLR still overrides.
  - This introduces a combinational out_ready -> in_ready path.
- Undefined: behaviour as in the main section; one idle cycle between blocks.

Test Plan:
- Reset and fill, DIR=0, DEPTH=16, WIDTH=8: drive RST low mid-stream, then feed 0x00..0x0F with in_valid held high.
  - Required: count goes 1..16 and in_ready drops after beat 16.
  - One cycle after the last beat, out_valid=1 and Dout[7:0]=0x00, Dout[127:120]=0x0F.
- Reverse order: DIR=1 at the first beat, then toggle DIR mid-block, feed 0xA0..0xAF.
  - Required: slot 15=0xA0, slot 0=0xAF; the DIR toggle has no effect.
- Backpressure: block full, out_ready=0 for 5 cycles while in_valid=1 with Din=0x55.
  - Required: Dout unchanged, count=16, in_ready=0.
  - Then assert out_ready for one cycle: Dout=0, count=0, out_valid=0; in_ready=1 the next cycle; 0x55 is then accepted into slot 0.
- Clear and reset mid-block: after 7 beats, pulse CLR with in_valid=1.
  - Required: count=0, the offered beat is dropped, Dout=0.
  - Repeat with async RST low between clock edges: outputs zero immediately, without waiting for a clock.
- Parameter sweep: WIDTH=8 with DEPTH=24 and 32, and WIDTH=32 with DEPTH=4, using random beats and random gaps in in_valid and out_ready.
  - Required: every presented block matches the reference model; no beat is lost or duplicated.
- With LEA_LOADER_ZERO_BUBBLE_EN: hold in_valid=1 and out_ready=1 continuously.
  - Required: in_ready stays 1 through the block boundary, 16 accepted beats per block, out_valid high exactly one cycle per block, and the 17th beat is in slot 0 of the next block.
